// File: rtl/toggle_activity_counter.sv
// Switching-activity monitor: samples a bus of monitored nets every clock
// inside a start/stop measurement window and keeps a saturating per-net
// toggle count plus a saturating total over all nets. A sticky flag records
// that some count has hit its ceiling. One registered read port returns a
// selected per-net count.
//
// Handshake: start, stop and clear are single-cycle pulses sampled on the
// rising clock edge; there is no back-pressure and every sampled pulse acts
// on that edge.
module toggle_activity_counter #(
   parameter int W     = 8,
   parameter int CNT_W = 16,
   parameter int TOT_W = 24,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic [W-1:0]     mon,
   input  logic [SEL_W-1:0] rd_sel,
   output logic [CNT_W-1:0] rd_data,
   output logic [TOT_W-1:0] total,
   output logic             busy,
   output logic             sat
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARM   = 2'd1;
   localparam logic [1:0] ST_COUNT = 2'd2;

   localparam int POP_W = $clog2(W + 1);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

   logic [1:0]       state_q, state_d;
   logic [W-1:0]     prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q [W];
   logic [CNT_W-1:0] cnt_d [W];
   logic [TOT_W-1:0] total_q, total_d;
   logic             sat_q, sat_d;
   logic             busy_q;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;

   logic [W-1:0]     tog;
   logic [POP_W-1:0] pop;
   logic [TOT_W:0]   tot_sum;

   // Window FSM: IDLE -> ARM (baseline sample) -> COUNT -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            // start and stop together cancel each other.
            if (start && !stop) state_d = ST_ARM;
         end
         ST_ARM: begin
            state_d = stop ? ST_IDLE : ST_COUNT;
         end
         ST_COUNT: begin
            // start is ignored while counting.
            if (stop) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Toggle detection and saturating count/total update; clear wins over increments.
   always_comb begin
      prev_d  = prev_q;
      tog     = '0;
      cnt_d   = cnt_q;
      total_d = total_q;
      sat_d   = sat_q;
      pop     = '0;
      tot_sum = '0;

      if (state_q == ST_ARM) begin
         prev_d = mon;
      end else if (state_q == ST_COUNT) begin
         // The stop cycle's toggles are still counted here.
         tog    = mon ^ prev_q;
         prev_d = mon;
      end

      for (int i = 0; i < W; i++) begin
         if (tog[i]) begin
            pop = pop + POP_W'(1);
            if (cnt_q[i] == CNT_MAX) sat_d = 1'b1;
            else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end

      tot_sum = {1'b0, total_q} + (TOT_W + 1)'(pop);
      if (tot_sum > {1'b0, TOT_MAX}) begin
         total_d = TOT_MAX;
         sat_d   = 1'b1;
      end else begin
         total_d = tot_sum[TOT_W-1:0];
      end

      // clear zeroes the counts in any state but leaves prev and the FSM alone.
      if (clear) begin
         for (int i = 0; i < W; i++) cnt_d[i] = '0;
         total_d = '0;
         sat_d   = 1'b0;
      end
   end

   // Read mux over the pre-update counts; out-of-range selects return zero.
   always_comb begin
      rd_data_d = '0;
      for (int i = 0; i < W; i++) begin
         if (SEL_W'(i) == rd_sel) rd_data_d = cnt_q[i];
      end
   end

   // State, datapath and read register update with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         prev_q    <= '0;
         for (int i = 0; i < W; i++) cnt_q[i] <= '0;
         total_q   <= '0;
         sat_q     <= 1'b0;
         busy_q    <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         for (int i = 0; i < W; i++) cnt_q[i] <= cnt_d[i];
         total_q   <= total_d;
         sat_q     <= sat_d;
         busy_q    <= (state_d != ST_IDLE);
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;
   assign total   = total_q;
   assign busy    = busy_q;
   assign sat     = sat_q;

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Bench for toggle_activity_counter: a default instance (W=8, CNT_W=16,
// TOT_W=24) and a narrow instance (W=6, CNT_W=4, TOT_W=6) share every
// control input. A cycle model pushes the expected read value on each
// driven cycle; it is popped one edge later when the registered read lands.
module tb_toggle_activity_counter;

   logic        clk;
   logic        reset, start, stop, clear;
   logic [7:0]  mon;
   logic [2:0]  rd_sel;
   logic [15:0] rd_data;
   logic [23:0] total;
   logic        busy, sat;
   logic [3:0]  rd_data_s;
   logic [5:0]  total_s;
   logic        busy_s, sat_s;

   int n_vec = 0;
   int n_err = 0;

   toggle_activity_counter u_dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .mon(mon), .rd_sel(rd_sel), .rd_data(rd_data), .total(total),
      .busy(busy), .sat(sat)
   );

   toggle_activity_counter #(.W(6), .CNT_W(4), .TOT_W(6), .SEL_W(3)) u_small (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .mon(mon[5:0]), .rd_sel(rd_sel), .rd_data(rd_data_s), .total(total_s),
      .busy(busy_s), .sat(sat_s)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model (index 0 = default instance, 1 = narrow instance)
   int         m_state;
   logic [7:0] m_prev [2];
   int         m_cnt  [2][8];
   int         m_tot  [2];
   logic       m_sat  [2];
   int         wn     [2] = '{8, 6};
   int         cmax   [2] = '{65535, 15};
   int         tmax   [2] = '{16777215, 63};

   logic [15:0] exp_q   [$];
   logic [3:0]  exp_s_q [$];
   logic [15:0] e_rd;
   logic [3:0]  e_rd_s;

   task automatic model_update();
      int         ns;
      int         pc;
      logic [7:0] tog;
      if (reset) begin
         m_state = 0;
         for (int k = 0; k < 2; k++) begin
            m_prev[k] = '0; m_tot[k] = 0; m_sat[k] = 1'b0;
            for (int i = 0; i < 8; i++) m_cnt[k][i] = 0;
         end
         exp_q.push_back(16'd0);
         exp_s_q.push_back(4'd0);
         return;
      end
      exp_q.push_back(16'(m_cnt[0][rd_sel]));
      exp_s_q.push_back((int'(rd_sel) < 6) ? 4'(m_cnt[1][rd_sel]) : 4'd0);
      ns = m_state;
      case (m_state)
         0: if (start && !stop) ns = 1;
         1: ns = stop ? 0 : 2;
         default: ns = stop ? 0 : 2;
      endcase
      for (int k = 0; k < 2; k++) begin
         if (m_state == 1) begin
            m_prev[k] = mon;
         end else if (m_state == 2) begin
            tog = mon ^ m_prev[k];
            m_prev[k] = mon;
            pc = 0;
            for (int i = 0; i < wn[k]; i++) begin
               if (tog[i]) begin
                  pc++;
                  if (m_cnt[k][i] == cmax[k]) m_sat[k] = 1'b1;
                  else m_cnt[k][i]++;
               end
            end
            if (m_tot[k] + pc > tmax[k]) begin
               m_tot[k] = tmax[k]; m_sat[k] = 1'b1;
            end else begin
               m_tot[k] += pc;
            end
         end
         if (clear) begin
            for (int i = 0; i < 8; i++) m_cnt[k][i] = 0;
            m_tot[k] = 0; m_sat[k] = 1'b0;
         end
      end
      m_state = ns;
   endtask

   // driver: apply current inputs for one clock, then collect expected read
   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      e_rd   = exp_q.pop_front();
      e_rd_s = exp_s_q.pop_front();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_vec += 6;
      if (rd_data !== 16'd0)  begin n_err++; $display("FAIL reset_rd_data got %0d exp 0", rd_data); end
      if (rd_data_s !== 4'd0) begin n_err++; $display("FAIL reset_rd_data_s got %0d exp 0", rd_data_s); end
      if (total !== 24'd0)    begin n_err++; $display("FAIL reset_total got %0d exp 0", total); end
      if (total_s !== 6'd0)   begin n_err++; $display("FAIL reset_total_s got %0d exp 0", total_s); end
      if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (sat !== 1'b0)       begin n_err++; $display("FAIL reset_sat got %b exp 0", sat); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      mon = 8'h00; start = 1'b1; step();
      start = 1'b0; step();                 // ARM: baseline 00
      mon = 8'h01; step();
      mon = 8'h00; step();
      mon = 8'h01; step();
      stop = 1'b1; step(); stop = 1'b0;
      n_vec += 3;
      if (busy !== 1'b0)     begin n_err++; $display("FAIL basic_busy got %b exp 0", busy); end
      if (total !== 24'd3)   begin n_err++; $display("FAIL basic_total got %0d exp 3", total); end
      if (total_s !== 6'd3)  begin n_err++; $display("FAIL basic_total_s got %0d exp 3", total_s); end
      for (int s = 0; s < 8; s++) begin
         rd_sel = 3'(s); step();
         n_vec += 2;
         if (rd_data !== e_rd || rd_data !== 16'((s == 0) ? 3 : 0)) begin
            n_err++; $display("FAIL basic_rd sel=%0d got %0d exp %0d", s, rd_data, e_rd);
         end
         if (rd_data_s !== e_rd_s) begin
            n_err++; $display("FAIL basic_rd_s sel=%0d got %0d exp %0d", s, rd_data_s, e_rd_s);
         end
      end
   endtask

   task automatic test_alternate();
      clear = 1'b1; step(); clear = 1'b0;
      mon = 8'h00; start = 1'b1; step();
      start = 1'b0; step();                 // ARM: baseline 00
      for (int c = 0; c < 10; c++) begin
         mon  = (c % 2 == 0) ? 8'hFF : 8'h00;
         stop = (c == 9);
         step();
      end
      stop = 1'b0;
      n_vec += 3;
      if (busy !== 1'b0)     begin n_err++; $display("FAIL alt_busy got %b exp 0", busy); end
      if (total !== 24'd80)  begin n_err++; $display("FAIL alt_total got %0d exp 80", total); end
      if (total_s !== 6'd60) begin n_err++; $display("FAIL alt_total_s got %0d exp 60", total_s); end
      for (int s = 0; s < 8; s++) begin
         rd_sel = 3'(s); step();
         n_vec += 2;
         if (rd_data !== e_rd || rd_data !== 16'd10) begin
            n_err++; $display("FAIL alt_rd sel=%0d got %0d exp 10", s, rd_data);
         end
         if (rd_data_s !== e_rd_s || rd_data_s !== 4'((s < 6) ? 10 : 0)) begin
            n_err++; $display("FAIL alt_rd_s sel=%0d got %0d exp %0d", s, rd_data_s, e_rd_s);
         end
      end
   endtask

   task automatic test_saturate();
      clear = 1'b1; step(); clear = 1'b0;
      mon = 8'h00; start = 1'b1; step();
      start = 1'b0; step();                 // ARM
      for (int c = 0; c < 20; c++) begin
         mon = mon ^ 8'h04; step();
      end
      rd_sel = 3'd2; step();
      n_vec += 6;
      if (rd_data_s !== 4'd15 || rd_data_s !== e_rd_s) begin n_err++; $display("FAIL sat_cnt_s got %0d exp 15", rd_data_s); end
      if (rd_data !== 16'd20 || rd_data !== e_rd)      begin n_err++; $display("FAIL sat_cnt got %0d exp 20", rd_data); end
      if (sat_s !== 1'b1)    begin n_err++; $display("FAIL sat_flag_s got %b exp 1", sat_s); end
      if (sat !== 1'b0)      begin n_err++; $display("FAIL sat_flag got %b exp 0", sat); end
      if (total_s !== 6'd20) begin n_err++; $display("FAIL sat_total_s got %0d exp 20", total_s); end
      if (busy !== 1'b1)     begin n_err++; $display("FAIL sat_busy got %b exp 1", busy); end
      clear = 1'b1; step(); clear = 1'b0;
      n_vec += 4;
      if (total !== 24'd0)  begin n_err++; $display("FAIL clr_total got %0d exp 0", total); end
      if (total_s !== 6'd0) begin n_err++; $display("FAIL clr_total_s got %0d exp 0", total_s); end
      if (sat_s !== 1'b0)   begin n_err++; $display("FAIL clr_sat_s got %b exp 0", sat_s); end
      if (busy !== 1'b1)    begin n_err++; $display("FAIL clr_busy got %b exp 1", busy); end
      step();
      n_vec += 2;
      if (rd_data_s !== 4'd0 || rd_data_s !== e_rd_s) begin n_err++; $display("FAIL clr_cnt_s got %0d exp 0", rd_data_s); end
      if (rd_data !== 16'd0 || rd_data !== e_rd)      begin n_err++; $display("FAIL clr_cnt got %0d exp 0", rd_data); end
   endtask

   task automatic test_start_stop();
      start = 1'b1; mon = mon ^ 8'h04; step(); start = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL cnt_start_busy got %b exp 1", busy); end
      mon = mon ^ 8'h04; step();
      step();
      n_vec++;
      if (rd_data !== 16'd2 || rd_data !== e_rd) begin n_err++; $display("FAIL cnt_start_rd got %0d exp 2", rd_data); end
      stop = 1'b1; step(); stop = 1'b0;
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy got %b exp 0", busy); end
      mon = 8'hAA; step();                  // idle: mon ignored
      start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL startstop_busy got %b exp 0", busy); end
      step();
      n_vec += 2;
      if (busy !== 1'b0) begin n_err++; $display("FAIL startstop_busy2 got %b exp 0", busy); end
      if (rd_data !== 16'd2 || rd_data !== e_rd) begin n_err++; $display("FAIL idle_hold_rd got %0d exp 2", rd_data); end
      start = 1'b1; step(); start = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL arm_busy got %b exp 1", busy); end
      stop = 1'b1; step(); stop = 1'b0;
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL arm_stop_busy got %b exp 0", busy); end
   endtask

   task automatic test_read_reset();
      mon = 8'h00; start = 1'b1; step();
      start = 1'b0; step();                 // ARM
      mon = 8'h08; step();
      mon = 8'h00; step();
      mon = 8'h08; step();
      rd_sel = 3'd3; step();
      n_vec++;
      if (rd_data !== 16'd3 || rd_data !== e_rd) begin n_err++; $display("FAIL rd_sel3 got %0d exp 3", rd_data); end
      rd_sel = 3'd7; step();
      n_vec += 2;
      if (rd_data_s !== 4'd0 || rd_data_s !== e_rd_s) begin n_err++; $display("FAIL rd_sel7_s got %0d exp 0", rd_data_s); end
      if (rd_data !== e_rd) begin n_err++; $display("FAIL rd_sel7 got %0d exp %0d", rd_data, e_rd); end
      mon = 8'hFF; step();
      reset = 1'b1; mon = 8'h00; step(); reset = 1'b0;
      n_vec += 4;
      if (busy !== 1'b0)    begin n_err++; $display("FAIL midrst_busy got %b exp 0", busy); end
      if (total !== 24'd0)  begin n_err++; $display("FAIL midrst_total got %0d exp 0", total); end
      if (total_s !== 6'd0) begin n_err++; $display("FAIL midrst_total_s got %0d exp 0", total_s); end
      if (sat !== 1'b0)     begin n_err++; $display("FAIL midrst_sat got %b exp 0", sat); end
      rd_sel = 3'd3; step();
      n_vec += 2;
      if (rd_data !== 16'd0) begin n_err++; $display("FAIL midrst_rd got %0d exp 0", rd_data); end
      if (busy !== 1'b0)     begin n_err++; $display("FAIL midrst_busy2 got %b exp 0", busy); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         reset  = ($urandom_range(0, 99) < 1);
         start  = ($urandom_range(0, 99) < 10);
         stop   = ($urandom_range(0, 99) < 5);
         clear  = ($urandom_range(0, 99) < 3);
         mon    = 8'($urandom_range(0, 255));
         rd_sel = 3'($urandom_range(0, 7));
         step();
         n_vec += 8;
         if (rd_data !== e_rd)     begin n_err++; $display("FAIL rnd_rd c=%0d got %0d exp %0d", c, rd_data, e_rd); end
         if (rd_data_s !== e_rd_s) begin n_err++; $display("FAIL rnd_rd_s c=%0d got %0d exp %0d", c, rd_data_s, e_rd_s); end
         if (total !== 24'(m_tot[0]))  begin n_err++; $display("FAIL rnd_total c=%0d got %0d exp %0d", c, total, m_tot[0]); end
         if (total_s !== 6'(m_tot[1])) begin n_err++; $display("FAIL rnd_total_s c=%0d got %0d exp %0d", c, total_s, m_tot[1]); end
         if (busy !== (m_state != 0))   begin n_err++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, busy, m_state != 0); end
         if (busy_s !== (m_state != 0)) begin n_err++; $display("FAIL rnd_busy_s c=%0d got %b exp %b", c, busy_s, m_state != 0); end
         if (sat !== m_sat[0])   begin n_err++; $display("FAIL rnd_sat c=%0d got %b exp %b", c, sat, m_sat[0]); end
         if (sat_s !== m_sat[1]) begin n_err++; $display("FAIL rnd_sat_s c=%0d got %b exp %b", c, sat_s, m_sat[1]); end
      end
      reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
      mon = 8'h00; rd_sel = 3'd0;
      test_reset();
      test_basic();
      test_alternate();
      test_saturate();
      test_start_stop();
      test_read_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
